// File: rtl/pixel_threshold_unit.sv
// Pixel threshold unit: fetches LANES-pixel words from image memory, compares
// each lane against a threshold latched at frame start, and streams one
// LANES-bit result per word through a 2-entry FIFO to the bit-packing stage.
// The per-lane ports are fixed at four lanes, so LANES must stay 4.
//
// Output stream handshake: a beat transfers on every rising clk edge where
// out_valid and out_ready are both 1. out_valid and pixel_out_* depend only on
// registered state (never on out_ready) and hold steady while out_ready is 0.
module pixel_threshold_unit #(
    parameter int PIXEL_W     = 8,
    parameter int LANES       = 4,
    parameter int FRAME_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     invert,
    input  logic [PIXEL_W-1:0]       threshold_0,
    input  logic [PIXEL_W-1:0]       threshold_1,
    input  logic [PIXEL_W-1:0]       threshold_2,
    input  logic [PIXEL_W-1:0]       threshold_3,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [LANES*PIXEL_W-1:0] mem_rd_data,
    output logic                     pixel_out_0,
    output logic                     pixel_out_1,
    output logic                     pixel_out_2,
    output logic                     pixel_out_3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               dbg_state
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [LANES-1:0][PIXEL_W-1:0]   thr_q, thr_d;
    logic                            inv_q, inv_d;
    logic [CNT_W-1:0]                issued_q, issued_d;
    logic [CNT_W-1:0]                accepted_q, accepted_d;
    logic                            inflight_q, inflight_d;
    logic [1:0][LANES-1:0]           fifo_q, fifo_d;
    logic                            rd_ptr_q, rd_ptr_d;
    logic                            wr_ptr_q, wr_ptr_d;
    logic [1:0]                      count_q, count_d;

    logic [LANES-1:0][PIXEL_W-1:0]   thr_in;
    logic [LANES-1:0]                cmp_bits;
    logic [LANES-1:0]                head;
    logic                            push;
    logic                            pop;
    logic [2:0]                      occupancy;

    // Compare the returning word lane by lane and derive stream/issue controls.
    always_comb begin
        thr_in    = '0;
        thr_in[0] = threshold_0;
        thr_in[1] = threshold_1;
        thr_in[2] = threshold_2;
        thr_in[3] = threshold_3;
        cmp_bits  = '0;
        for (int k = 0; k < LANES; k++) begin
            cmp_bits[k] = (mem_rd_data[k*PIXEL_W +: PIXEL_W] > thr_q[k]) ^ inv_q;
        end
        out_valid = (count_q != 2'd0);
        pop       = out_valid & out_ready;
        push      = inflight_q;
        // Entries held plus the read still in flight, after this cycle's pop.
        occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        mem_rd_en = (state_q == ST_RUN) &&
                    (issued_q < CNT_W'(FRAME_WORDS)) &&
                    (occupancy < 3'd2);
        mem_addr  = ADDR_W'(issued_q);
        head      = fifo_q[rd_ptr_q];
        pixel_out_0 = out_valid & head[0];
        pixel_out_1 = out_valid & head[1];
        pixel_out_2 = out_valid & head[2];
        pixel_out_3 = out_valid & head[3];
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        done      = (state_q == ST_DONE);
        dbg_state = state_q;
    end

    // Frame FSM next state plus counter, latch and FIFO updates.
    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        inv_d      = inv_q;
        issued_d   = issued_q + CNT_W'(mem_rd_en);
        accepted_d = accepted_q + CNT_W'(pop);
        inflight_d = mem_rd_en;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q ^ pop;
        wr_ptr_d   = wr_ptr_q ^ push;
        count_d    = count_q + 2'(push) - 2'(pop);
        if (push) begin
            fifo_d[wr_ptr_q] = cmp_bits;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thr_d      = thr_in;
                    inv_d      = invert;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Leave as the final pop happens so done lands the next cycle.
                if (accepted_d == CNT_W'(FRAME_WORDS)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            thr_q      <= '0;
            inv_q      <= 1'b0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            fifo_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            inv_q      <= inv_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_pixel_threshold_unit.sv
// Testbench for pixel_threshold_unit with a 16-word frame and a 1-cycle
// latency memory model. A background monitor scoreboards every beat, address
// and done pulse; scenario tasks add their own targeted checks.
module tb_pixel_threshold_unit;

    localparam int PW = 8;
    localparam int LN = 4;
    localparam int FW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          invert;
    logic [PW-1:0] threshold_0, threshold_1, threshold_2, threshold_3;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [LN*PW-1:0] mem_rd_data;
    logic          pixel_out_0, pixel_out_1, pixel_out_2, pixel_out_3;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    logic [3:0]    pix_bus;
    assign pix_bus = {pixel_out_3, pixel_out_2, pixel_out_1, pixel_out_0};

    pixel_threshold_unit #(
        .PIXEL_W(PW), .LANES(LN), .FRAME_WORDS(FW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .invert(invert),
        .threshold_0(threshold_0), .threshold_1(threshold_1),
        .threshold_2(threshold_2), .threshold_3(threshold_3),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pixel_out_0(pixel_out_0), .pixel_out_1(pixel_out_1),
        .pixel_out_2(pixel_out_2), .pixel_out_3(pixel_out_3),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] mem [FW];
    logic [3:0]  exp_q [$];
    int          exp_addr = 0;
    int          popped = 0;
    bit          done_due = 0;
    bit          mon_en = 0;
    bit          hold_start = 0;
    logic        pend_v = 1'b0;
    logic [AW-1:0] pend_a = '0;

    // Reference rule: a lane is 1 when the pixel is strictly above its
    // threshold, then the whole word is flipped when invert was latched.
    function automatic logic [3:0] exp_bits(input logic [31:0] w,
                                            input logic [7:0] t0, input logic [7:0] t1,
                                            input logic [7:0] t2, input logic [7:0] t3,
                                            input logic inv);
        int t [4];
        logic [3:0] r;
        t[0] = int'(t0); t[1] = int'(t1); t[2] = int'(t2); t[3] = int'(t3);
        for (int k = 0; k < 4; k++) begin
            int p;
            p = int'((w >> (8 * k)) & 32'hFF);
            r[k] = ((p > t[k]) ? 1'b1 : 1'b0) ^ inv;
        end
        return r;
    endfunction

    // ---------------- memory model ----------------
    always @(negedge clk) begin
        #1;
        pend_v = mem_rd_en;
        pend_a = mem_addr;
    end

    always @(posedge clk) begin
        if (pend_v) mem_rd_data <= mem[pend_a];
        else        mem_rd_data <= $urandom;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        #1;
        if (mon_en && !reset) begin
            n_checks++;
            if (done !== done_due) begin
                n_errors++;
                $display("FAIL done_pulse cyc=%0d got=%b exp=%b", cyc, done, done_due);
            end
            done_due = 0;
            if (mem_rd_en) begin
                n_checks++;
                if (exp_addr >= FW || mem_addr !== AW'(exp_addr)) begin
                    n_errors++;
                    $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, mem_addr, exp_addr);
                end
                exp_addr++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_beat cyc=%0d got=%b exp=none", cyc, pix_bus);
                end else begin
                    if (pix_bus !== exp_q[0]) begin
                        n_errors++;
                        $display("FAIL beat_data cyc=%0d beat=%0d got=%b exp=%b",
                                 cyc, popped, pix_bus, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                popped++;
                if (popped == FW) done_due = 1;
            end
            n_checks++;
            if (exp_addr - popped > 2) begin
                n_errors++;
                $display("FAIL occupancy cyc=%0d got=%0d exp<=2", cyc, exp_addr - popped);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int mode);
        @(negedge clk);
        cyc++;
        start = hold_start;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 2 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = !(cyc >= 3 && cyc <= 10);
        endcase
        #2;
    endtask

    task automatic fill_random();
        for (int a = 0; a < FW; a++) mem[a] = $urandom;
    endtask

    task automatic start_frame(input logic [7:0] t0, input logic [7:0] t1,
                               input logic [7:0] t2, input logic [7:0] t3,
                               input logic inv);
        @(negedge clk);
        start = 1'b1;
        threshold_0 = t0; threshold_1 = t1; threshold_2 = t2; threshold_3 = t3;
        invert = inv;
        out_ready = 1'b1;
        exp_q.delete();
        for (int a = 0; a < FW; a++) exp_q.push_back(exp_bits(mem[a], t0, t1, t2, t3, inv));
        exp_addr = 0;
        popped = 0;
        done_due = 0;
        mon_en = 1;
        cyc = 0;
        #2;
    endtask

    task automatic run_to_done(input int mode, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            step(mode);
            if (done === 1'b1) begin
                done_cyc = cyc;
                hold_start = 0;
                break;
            end
        end
        n_checks++;
        if (done_cyc < 0) begin
            n_errors++;
            $display("FAIL done_timeout got=no_done exp=done_within_400");
        end else begin
            step(mode);
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_drop cyc=%0d got=%b exp=0", cyc, busy);
            end
        end
        n_checks++;
        if (popped != FW || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL beat_count got=%0d exp=%0d left=%0d", popped, FW, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 0; invert = 0; out_ready = 0;
        threshold_0 = 0; threshold_1 = 0; threshold_2 = 0; threshold_3 = 0;
        #1;
        n_checks++;
        if ({mem_rd_en, mem_addr, pix_bus, out_valid, busy, done} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {mem_rd_en, mem_addr, pix_bus, out_valid, busy, done});
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(0);
        n_checks++;
        if ({mem_rd_en, busy, out_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_after_reset got=%b exp=000", {mem_rd_en, busy, out_valid});
        end
    endtask

    task automatic test_basic_frame();
        int dc;
        fill_random();
        mem[0] = 32'h81807FFF;
        start_frame(8'h80, 8'h80, 8'h80, 8'h80, 1'b0);
        step(0);
        n_checks++;
        if ({mem_rd_en, mem_addr, busy, out_valid} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL basic_cycle1 got=%b exp=1000010", {mem_rd_en, mem_addr, busy, out_valid});
        end
        step(0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_cycle2_valid got=%b exp=0", out_valid);
        end
        step(0);
        n_checks++;
        if (out_valid !== 1'b1 || pix_bus !== 4'b1001) begin
            n_errors++;
            $display("FAIL basic_first_beat got=%b/%b exp=1/1001", out_valid, pix_bus);
        end
        run_to_done(0, dc);
        n_checks++;
        if (dc != 3 + FW) begin
            n_errors++;
            $display("FAIL basic_done_cycle got=%0d exp=%0d", dc, 3 + FW);
        end
    endtask

    task automatic test_lane_invert();
        int dc;
        for (int a = 0; a < FW; a++) mem[a] = 32'h25252525;
        start_frame(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
        repeat (3) step(0);
        n_checks++;
        if (out_valid !== 1'b1 || pix_bus !== 4'b1100) begin
            n_errors++;
            $display("FAIL lane_invert got=%b/%b exp=1/1100", out_valid, pix_bus);
        end
        run_to_done(0, dc);
    endtask

    task automatic test_backpressure();
        int dc;
        logic [3:0] head;
        fill_random();
        start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        step(3);
        step(3);
        step(3);
        head = pix_bus;
        for (int c = 3; c <= 10; c++) begin
            if (c > 3) step(3);
            n_checks++;
            if (out_valid !== 1'b1 || pix_bus !== head || exp_addr != 2) begin
                n_errors++;
                $display("FAIL backpressure_hold cyc=%0d got=%b/%b/%0d exp=1/%b/2",
                         cyc, out_valid, pix_bus, exp_addr, head);
            end
        end
        run_to_done(3, dc);
    endtask

    task automatic test_alternating();
        int dc;
        fill_random();
        start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        run_to_done(1, dc);
        n_checks++;
        if (exp_addr != FW) begin
            n_errors++;
            $display("FAIL alt_reads got=%0d exp=%0d", exp_addr, FW);
        end
    endtask

    task automatic test_back_to_back_start();
        int dc;
        fill_random();
        start_frame(8'h40, 8'h80, 8'hC0, 8'h20, 1'b0);
        hold_start = 1;
        for (int i = 0; i < 5; i++) step(2);
        threshold_0 = 8'hFF; threshold_1 = 8'h00; threshold_2 = 8'h00; threshold_3 = 8'hFF;
        invert = 1'b1;
        run_to_done(2, dc);
        for (int i = 0; i < 4; i++) begin
            step(0);
            n_checks++;
            if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
                n_errors++;
                $display("FAIL no_restart cyc=%0d got=%b%b exp=00", cyc, busy, mem_rd_en);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int dc;
        fill_random();
        start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 20 && popped < 2; i++) step(0);
        mon_en = 0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_rd_en, mem_addr, pix_bus, out_valid, busy, done} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs got=%b exp=0",
                     {mem_rd_en, mem_addr, pix_bus, out_valid, busy, done});
        end
        for (int i = 0; i < 3; i++) begin
            step(0);
            n_checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_hold got=%b%b exp=00", done, out_valid);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        fill_random();
        start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        step(2);
        n_checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 4'd0) begin
            n_errors++;
            $display("FAIL restart_addr got=%b/%0d exp=1/0", mem_rd_en, mem_addr);
        end
        run_to_done(2, dc);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_frame();
        test_lane_invert();
        test_backpressure();
        test_alternating();
        test_back_to_back_start();
        for (int r = 0; r < 3; r++) begin
            int dc;
            fill_random();
            start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            run_to_done(2, dc);
        end
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
